// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-byte FIFO between the UART rx path and the CPU IO read mux, with registered io_dout.
// Optional: define UART_RX_FIFO_LEVEL_EN to expose the fill level at LEVEL_ADDR.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [7:0]  DATA_ADDR  = 8'h80,
  parameter logic [7:0]  STAT_ADDR  = 8'h83,
  parameter logic [7:0]  LEVEL_ADDR = 8'h84
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  input  logic [7:0] cpu_addr,
  input  logic       cpu_io,
  input  logic       cpu_rd,
  output logic [7:0] io_dout,
  output logic       rx_not_empty,
  output logic       rx_overflow
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            dout_q, dout_d;
  logic                  ovf_q, ovf_d;
  logic                  rd_prev_q, rd_prev_d;
  logic                  full, empty, rd_edge, pop, push, drop, clr;

  always_comb begin
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
    // One action per CPU read, regardless of how long the strobe is held.
    rd_edge   = cpu_rd & cpu_io & ~rd_prev_q;
    rd_prev_d = cpu_rd & cpu_io;
    pop       = rd_edge & (cpu_addr == DATA_ADDR) & ~empty;
    clr       = rd_edge & (cpu_addr == STAT_ADDR);
    // A same-cycle pop frees the slot, so a push while full is still accepted.
    push      = rx_valid & (~full | pop);
    drop      = rx_valid & full & ~pop;
    wptr_d    = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d   = count_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    ovf_d     = drop | (ovf_q & ~clr);

    dout_d = dout_q;
    if (cpu_io) begin
      if (cpu_addr == DATA_ADDR) begin
        dout_d = empty ? 8'h00 : mem_q[rptr_q];
      end else if (cpu_addr == STAT_ADDR) begin
        dout_d = {ovf_q, full, 1'b0, ~empty, 3'b000, tx_busy};
`ifdef UART_RX_FIFO_LEVEL_EN
      end else if (cpu_addr == LEVEL_ADDR) begin
        dout_d = 8'(count_q);
`else
      end else if (cpu_addr == LEVEL_ADDR) begin
        dout_d = dout_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      dout_q    <= 8'h00;
      ovf_q     <= 1'b0;
      rd_prev_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
      rd_prev_q <= rd_prev_d;
    end
  end

  // Storage is deliberately not reset; count/pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= rx_data;
  end

  assign io_dout      = dout_q;
  assign rx_not_empty = ~empty;
  assign rx_overflow  = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam logic [7:0] DATA  = 8'h80;
  localparam logic [7:0] STAT  = 8'h83;
  localparam logic [7:0] LEVEL = 8'h84;
  localparam logic [7:0] OTHER = 8'h81;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid, tx_busy, cpu_io, cpu_rd;
  logic [7:0] rx_data, cpu_addr, io_dout;
  logic       rx_not_empty, rx_overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic [7:0] m_dout;
  logic       m_ovf, m_rd;

  uart_rx_fifo dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .cpu_addr(cpu_addr), .cpu_io(cpu_io), .cpu_rd(cpu_rd),
    .io_dout(io_dout), .rx_not_empty(rx_not_empty), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the register-level rules, compare all outputs.
  task automatic step(input bit v, input logic [7:0] d, input bit io, input bit rd, input logic [7:0] a);
    bit e, pop, clr, drop, full;
    rx_valid = v; rx_data = d; cpu_io = io; cpu_rd = rd; cpu_addr = a;
    @(posedge clk); #1;
    full = (mq.size() == DEPTH);
    e    = rd && io && !m_rd;
    pop  = e && (a == DATA) && (mq.size() != 0);
    clr  = e && (a == STAT);
    if (io) begin
      if (a == DATA) m_dout = (mq.size() == 0) ? 8'h00 : mq[0];
      else if (a == STAT) m_dout = {m_ovf, full, 1'b0, mq.size() != 0, 3'b000, tx_busy};
`ifdef UART_RX_FIFO_LEVEL_EN
      else if (a == LEVEL) m_dout = 8'(mq.size());
`endif
    end
    if (pop) void'(mq.pop_front());
    drop = 1'b0;
    if (v) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_rd = rd && io;
    check("dout", io_dout, m_dout);
    check("not_empty", 8'(rx_not_empty), 8'(mq.size() != 0));
    check("ovf", 8'(rx_overflow), 8'(m_ovf));
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, OTHER);
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    cpu_io = 1'b0; cpu_rd = 1'b0; cpu_addr = 8'h00;
    mq.delete(); m_dout = 8'h00; m_ovf = 1'b0; m_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", io_dout, 8'h00);
    check("rst_ne", 8'(rx_not_empty), 8'h00);
    check("rst_ovf", 8'(rx_overflow), 8'h00);
    reset = 1'b0;

    step(1'b0, 8'h00, 1'b1, 1'b1, STAT);  check("stat_rst", io_dout, 8'h00);
    idle();
    step(1'b0, 8'h00, 1'b1, 1'b1, DATA);  check("data_rst", io_dout, 8'h00);
    idle();

    // Three bytes, each read with the strobe held three cycles.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0, OTHER);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b1, DATA);
      check("rd_byte", io_dout, 8'h41 + 8'(i));
      step(1'b0, 8'h00, 1'b1, 1'b1, DATA);
      step(1'b0, 8'h00, 1'b1, 1'b1, DATA);
      idle();
    end
    step(1'b0, 8'h00, 1'b1, 1'b1, STAT);  check("stat_b4", 8'(io_dout[4]), 8'h00);
    idle();

    // Overflow: 17 pushes into 16 entries.
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0, OTHER);
    step(1'b0, 8'h00, 1'b1, 1'b1, STAT);  check("stat_ovf", io_dout, 8'hD0);
    idle();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b1, DATA);
      check("drain", io_dout, 8'(i));
      idle();
    end
    step(1'b0, 8'h00, 1'b1, 1'b1, STAT);  check("stat_clr", io_dout, 8'h00);
    idle();

    // Asynchronous reset with 8 entries queued.
    for (int i = 0; i < 8; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, OTHER);
    step(1'b0, 8'h00, 1'b1, 1'b0, DATA);
    reset = 1'b1;
    #2;
    check("arst_dout", io_dout, 8'h00);
    check("arst_ne", 8'(rx_not_empty), 8'h00);
    mq.delete(); m_dout = 8'h00; m_ovf = 1'b0; m_rd = 1'b0;
    reset = 1'b0;
    step(1'b0, 8'h00, 1'b1, 1'b1, DATA);  check("arst_data", io_dout, 8'h00);
    idle();

`ifdef UART_RX_FIFO_LEVEL_EN
    for (int i = 0; i < 3; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, OTHER);
    step(1'b0, 8'h00, 1'b1, 1'b1, LEVEL); check("level", io_dout, 8'h03);
    idle();
    step(1'b0, 8'h00, 1'b1, 1'b1, LEVEL); check("level_again", io_dout, 8'h03);
    idle();
    for (int i = 0; i < 3; i++) begin step(1'b0, 8'h00, 1'b1, 1'b1, DATA); idle(); end
`endif

    // Same-cycle push and pop with 5 entries queued, then interleaved traffic through wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, OTHER);
    step(1'b1, 8'hA5, 1'b1, 1'b1, DATA);  check("pushpop_rd", io_dout, 8'hA0);
    check("pushpop_cnt", 8'(mq.size()), 8'd5);
    idle();
`ifdef UART_RX_FIFO_LEVEL_EN
    step(1'b0, 8'h00, 1'b1, 1'b1, LEVEL); check("pushpop_level", io_dout, 8'h05);
    idle();
`endif
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) step(1'b1, 8'hB0 + 8'(i), 1'b1, 1'b1, DATA);
      else            step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, OTHER);
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] a;
      case ($urandom_range(0, 4))
        0, 1:    a = DATA;
        2:       a = STAT;
        3:       a = LEVEL;
        default: a = OTHER;
      endcase
      tx_busy = 1'($urandom_range(0, 1));
      step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
